// File: rtl/clock_phase_gen.sv
// Purpose : programmable clock-divider bank; NUM_CH divided clocks with per-channel half-period, phase, polarity and enable strobe.
// Latency : cfg_wr takes effect at the end of the current full output period (<= 2*H_old cycles); sync takes effect on the next edge.
// Backpr. : none; writes are always accepted (last write wins), out-of-range channel writes are dropped and flagged on cfg_err.
//
// Ports:
//   clock     master clock, all state updates on its rising edge
//   reset     synchronous active-high reset, highest priority
//   sync      one-cycle pulse realigning every channel to its phase offset
//   cfg_wr    configuration write strobe; cfg_ch selects the channel
//   cfg_half  half-period in master cycles (0 behaves as 1)
//   cfg_phase initial counter offset (clamped to half-1)
//   cfg_inv   output polarity invert
//   clk_out   registered divided clocks
//   en_out    one-cycle strobe in the cycle each internal clock goes high
//   pending   a shadow configuration is waiting for its channel's period end
//   cfg_err   one-cycle pulse after a write to a non-existent channel
module clock_phase_gen #(
    parameter int                 NUM_CH   = 4,
    parameter int                 CNT_W    = 8,
    parameter logic [NUM_CH-1:0]  INV_MASK = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sync,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              cfg_inv,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] en_out,
    output logic [NUM_CH-1:0] pending,
    output logic              cfg_err
);

    // One channel's programmable settings, always held in normalised form
    // (half >= 1, phase < half) so the counting logic never sees bad values.
    typedef struct packed {
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] phase;
        logic             inv;
    } chan_cfg_t;

    function automatic chan_cfg_t normalize(input logic [CNT_W-1:0] h,
                                            input logic [CNT_W-1:0] p,
                                            input logic             inv);
        chan_cfg_t c;
        c.half  = (h == '0) ? CNT_W'(1) : h;
        c.phase = (p >= c.half) ? (c.half - CNT_W'(1)) : p;
        c.inv   = inv;
        return c;
    endfunction

    // Reset half-period 2^i reproduces the legacy /2, /4, ... chain;
    // saturates once 2^i no longer fits in CNT_W bits.
    function automatic logic [CNT_W-1:0] reset_half(input int idx);
        if (idx >= CNT_W) begin
            return '1;
        end
        return CNT_W'(1) << idx;
    endfunction

    // Active and shadow state
    chan_cfg_t        act_q [NUM_CH];
    chan_cfg_t        shd_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [NUM_CH-1:0] ci_q;

    // Next-state values
    chan_cfg_t        act_d [NUM_CH];
    chan_cfg_t        shd_d [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ci_d;
    logic [NUM_CH-1:0] en_d;
    logic [NUM_CH-1:0] pend_d;

    logic      wr_ok;
    logic      wr_err;
    chan_cfg_t wr_cfg;

    assign wr_ok  = cfg_wr && ({1'b0, cfg_ch} <  5'(NUM_CH));
    assign wr_err = cfg_wr && ({1'b0, cfg_ch} >= 5'(NUM_CH));
    assign wr_cfg = normalize(cfg_half, cfg_phase, cfg_inv);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            logic      wr_hit;
            logic      last;
            chan_cfg_t src;

            act_d[i]  = act_q[i];
            shd_d[i]  = shd_q[i];
            cnt_d[i]  = cnt_q[i];
            ci_d[i]   = ci_q[i];
            en_d[i]   = 1'b0;
            pend_d[i] = pending[i];

            wr_hit = wr_ok && (cfg_ch == 4'(i));
            last   = (cnt_q[i] == (act_q[i].half - CNT_W'(1)));
            // A write landing on the same edge as an application is used
            // directly, so the newest settings are never left stranded.
            src    = wr_hit ? wr_cfg : shd_q[i];

            if (sync) begin
                if (wr_hit || pending[i]) begin
                    act_d[i]  = src;
                    pend_d[i] = 1'b0;
                end
                cnt_d[i] = act_d[i].phase;
                ci_d[i]  = 1'b0;
            end else if (last && ci_q[i] && pending[i]) begin
                // End of a full high/low period: safe point to switch
                // settings without truncating a period or making a runt.
                act_d[i]  = src;
                pend_d[i] = 1'b0;
                cnt_d[i]  = act_d[i].phase;
                ci_d[i]   = 1'b0;
            end else begin
                if (wr_hit) begin
                    shd_d[i]  = wr_cfg;
                    pend_d[i] = 1'b1;
                end
                if (last) begin
                    cnt_d[i] = '0;
                    ci_d[i]  = ~ci_q[i];
                    en_d[i]  = ~ci_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                act_q[i].half  <= reset_half(i);
                act_q[i].phase <= '0;
                act_q[i].inv   <= INV_MASK[i];
                shd_q[i].half  <= reset_half(i);
                shd_q[i].phase <= '0;
                shd_q[i].inv   <= INV_MASK[i];
                cnt_q[i]       <= '0;
            end
            ci_q    <= '0;
            en_out  <= '0;
            pending <= '0;
            clk_out <= INV_MASK;
            cfg_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                act_q[i]   <= act_d[i];
                shd_q[i]   <= shd_d[i];
                cnt_q[i]   <= cnt_d[i];
                // Output polarity folded in before the flop so clk_out is a
                // pure register output even when ci and inv change together.
                clk_out[i] <= ci_d[i] ^ act_d[i].inv;
            end
            ci_q    <= ci_d;
            en_out  <= en_d;
            pending <= pend_d;
            cfg_err <= wr_err;
        end
    end

endmodule

// File: tb/tb_clock_phase_gen.sv
module tb_clock_phase_gen;

    localparam int         NC    = 4;
    localparam logic [3:0] IMASK = 4'b1000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sync = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_ch = 4'd0;
    logic [7:0] cfg_half = 8'd0;
    logic [7:0] cfg_phase = 8'd0;
    logic       cfg_inv = 1'b0;
    logic [3:0] clk_out;
    logic [3:0] en_out;
    logic [3:0] pending;
    logic       cfg_err;

    clock_phase_gen #(
        .NUM_CH   (NC),
        .CNT_W    (8),
        .INV_MASK (IMASK)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sync      (sync),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_phase (cfg_phase),
        .cfg_inv   (cfg_inv),
        .clk_out   (clk_out),
        .en_out    (en_out),
        .pending   (pending),
        .cfg_err   (cfg_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: each channel is a position k = phase + edges-since-load on an
    // ideal square wave of half-period H; ci = floor(k/H) mod 2.
    int mH [NC];
    int mP [NC];
    int mn [NC];
    bit minv [NC];
    bit mpend [NC];
    int sH [NC];
    int sP [NC];
    bit sinv [NC];
    bit merr;

    function automatic int norm_h(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic int norm_p(input int h, input int p);
        int hh;
        hh = norm_h(h);
        return (p >= hh) ? hh - 1 : p;
    endfunction

    task automatic model_step();
        bit wr_ok;
        bit hit;
        int k;
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                mH[c] = (c < 8) ? (1 << c) : 255;
                mP[c] = 0;
                mn[c] = 0;
                minv[c] = IMASK[c];
                mpend[c] = 1'b0;
            end
            merr = 1'b0;
        end else begin
            wr_ok = cfg_wr && (int'(cfg_ch) < NC);
            for (int c = 0; c < NC; c++) begin
                hit = wr_ok && (int'(cfg_ch) == c);
                k = mP[c] + mn[c];
                if (sync || (mpend[c] && ((k + 1) % (2 * mH[c])) == 0)) begin
                    if (hit) begin
                        mH[c] = norm_h(int'(cfg_half));
                        mP[c] = norm_p(int'(cfg_half), int'(cfg_phase));
                        minv[c] = cfg_inv;
                    end else if (mpend[c]) begin
                        mH[c] = sH[c];
                        mP[c] = sP[c];
                        minv[c] = sinv[c];
                    end
                    mn[c] = 0;
                    mpend[c] = 1'b0;
                end else begin
                    if (hit) begin
                        sH[c] = norm_h(int'(cfg_half));
                        sP[c] = norm_p(int'(cfg_half), int'(cfg_phase));
                        sinv[c] = cfg_inv;
                        mpend[c] = 1'b1;
                    end
                    mn[c] = mn[c] + 1;
                end
            end
            merr = cfg_wr && (int'(cfg_ch) >= NC);
        end
    endtask

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        logic [3:0] eck;
        logic [3:0] een;
        logic [3:0] epd;
        int k;
        for (int c = 0; c < NC; c++) begin
            k = mP[c] + mn[c];
            eck[c] = (((k / mH[c]) % 2) == 1) ^ minv[c];
            een[c] = ((k % (2 * mH[c])) == mH[c]);
            epd[c] = mpend[c];
        end
        cmp("model clk_out", clk_out, eck);
        cmp("model en_out", en_out, een);
        cmp("model pending", pending, epd);
        cmp("model cfg_err", {3'b000, cfg_err}, {3'b000, merr});
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        if (reset) cyc = 0;
        else cyc++;
        #1;
        model_check();
    endtask

    task automatic run_to(input int e);
        while (cyc < e) tick();
    endtask

    task automatic set_wr(input logic [3:0] ch, input logic [7:0] h, input logic [7:0] p, input logic inv);
        cfg_wr = 1'b1;
        cfg_ch = ch;
        cfg_half = h;
        cfg_phase = p;
        cfg_inv = inv;
    endtask

    task automatic clr_wr();
        cfg_wr = 1'b0;
        cfg_ch = 4'd0;
        cfg_half = 8'd0;
        cfg_phase = 8'd0;
        cfg_inv = 1'b0;
    endtask

    logic [8:1] lit_ck0;
    logic [8:1] lit_en1;

    initial begin
        lit_ck0 = 8'b01010101;   // ch0 high on odd edges
        lit_en1 = 8'b00100010;   // ch1 strobe on edges 2 and 6

        // Reset; the last reset edge is edge 0.
        reset = 1'b1;
        repeat (3) tick();
        cmp("reset clk_out", clk_out, 4'b1000);
        cmp("reset en_out", en_out, 4'b0000);
        cmp("reset pending", pending, 4'b0000);
        cmp("reset cfg_err", {3'b000, cfg_err}, 4'b0000);
        reset = 1'b0;

        // Default dividers
        for (int e = 1; e <= 8; e++) begin
            tick();
            cmp("ch0 default clk", {3'b000, clk_out[0]}, {3'b000, lit_ck0[e]});
            cmp("ch1 default en", {3'b000, en_out[1]}, {3'b000, lit_en1[e]});
        end
        cmp("ch2 default clk@8", {3'b000, clk_out[2]}, 4'b0000);
        cmp("ch3 default clk@8", {3'b000, clk_out[3]}, 4'b0000);

        // ch2 half=3 phase=1, written mid-period, applied at edge 16
        run_to(9);
        set_wr(4'd2, 8'd3, 8'd1, 1'b0);
        tick();
        clr_wr();
        cmp("ch2 pending after write", {3'b000, pending[2]}, 4'b0001);
        run_to(15);
        cmp("ch2 pending@15", {3'b000, pending[2]}, 4'b0001);
        tick();
        cmp("ch2 pending@16", {3'b000, pending[2]}, 4'b0000);
        tick();
        cmp("ch2 clk@17", {3'b000, clk_out[2]}, 4'b0000);
        tick();
        cmp("ch2 clk@18", {3'b000, clk_out[2]}, 4'b0001);
        cmp("ch2 en@18", {3'b000, en_out[2]}, 4'b0001);
        run_to(20);
        cmp("ch2 clk@20", {3'b000, clk_out[2]}, 4'b0001);
        tick();
        cmp("ch2 clk@21", {3'b000, clk_out[2]}, 4'b0000);

        // ch1 half=2 phase=5 -> phase clamped to 1, applied at edge 24
        set_wr(4'd1, 8'd2, 8'd5, 1'b0);
        tick();
        clr_wr();
        tick();
        cmp("ch1 pending@23", {3'b000, pending[1]}, 4'b0001);
        tick();
        cmp("ch1 clk@24", {3'b000, clk_out[1]}, 4'b0000);
        cmp("ch1 pending@24", {3'b000, pending[1]}, 4'b0000);
        tick();
        cmp("ch1 clk@25", {3'b000, clk_out[1]}, 4'b0001);
        cmp("ch1 en@25", {3'b000, en_out[1]}, 4'b0001);

        // ch3: half 5 then half 7 before its edge-32 boundary; last wins
        set_wr(4'd3, 8'd5, 8'd0, 1'b1);
        tick();
        set_wr(4'd3, 8'd7, 8'd0, 1'b1);
        tick();
        clr_wr();
        run_to(31);
        cmp("ch3 pending@31", {3'b000, pending[3]}, 4'b0001);
        tick();
        cmp("ch3 clk@32", {3'b000, clk_out[3]}, 4'b0001);
        cmp("ch3 pending@32", {3'b000, pending[3]}, 4'b0000);
        run_to(38);
        cmp("ch3 clk@38", {3'b000, clk_out[3]}, 4'b0001);
        tick();
        cmp("ch3 clk@39", {3'b000, clk_out[3]}, 4'b0000);
        cmp("ch3 en@39", {3'b000, en_out[3]}, 4'b0001);
        run_to(45);
        cmp("ch3 clk@45", {3'b000, clk_out[3]}, 4'b0000);
        tick();
        cmp("ch3 clk@46", {3'b000, clk_out[3]}, 4'b0001);
        run_to(53);
        cmp("ch3 clk@53", {3'b000, clk_out[3]}, 4'b0000);
        cmp("ch3 en@53", {3'b000, en_out[3]}, 4'b0001);

        // Write to channel 9: error pulse only
        set_wr(4'd9, 8'd1, 8'd0, 1'b1);
        tick();
        clr_wr();
        cmp("bad ch cfg_err@54", {3'b000, cfg_err}, 4'b0001);
        cmp("bad ch pending@54", pending, 4'b0000);
        tick();
        cmp("bad ch cfg_err@55", {3'b000, cfg_err}, 4'b0000);

        // Pending ch2 plus a same-cycle ch0 write, both applied by sync at 60
        run_to(57);
        set_wr(4'd2, 8'd2, 8'd1, 1'b0);
        tick();
        clr_wr();
        tick();
        cmp("ch2 pending@59", {3'b000, pending[2]}, 4'b0001);
        sync = 1'b1;
        set_wr(4'd0, 8'd1, 8'd0, 1'b1);
        tick();
        sync = 1'b0;
        clr_wr();
        cmp("sync clk_out@60", clk_out, 4'b1001);
        cmp("sync en_out@60", en_out, 4'b0000);
        cmp("sync pending@60", pending, 4'b0000);
        tick();
        cmp("ch0 clk@61", {3'b000, clk_out[0]}, 4'b0000);
        cmp("ch2 clk@61", {3'b000, clk_out[2]}, 4'b0001);

        // Reset mid-period with a write pending
        run_to(63);
        set_wr(4'd1, 8'd3, 8'd0, 1'b1);
        tick();
        clr_wr();
        tick();
        cmp("ch1 pending@65", {3'b000, pending[1]}, 4'b0001);
        reset = 1'b1;
        tick();
        cmp("mid reset clk_out", clk_out, 4'b1000);
        cmp("mid reset pending", pending, 4'b0000);
        cmp("mid reset en_out", en_out, 4'b0000);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            cmp("ch0 after reset clk", {3'b000, clk_out[0]}, {3'b000, lit_ck0[e]});
            cmp("ch1 after reset en", {3'b000, en_out[1]}, {3'b000, lit_en1[e]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_phase_gen.md
Name: clock_phase_gen

Overview:
- Parametrised, programmable clock-divider bank; successor to the fixed ÷2/÷4 divider chain in the processor top level.
- Produces NUM_CH divided clock outputs, each with runtime-programmable half-period, phase offset and polarity.
- Each output also has a one-cycle enable strobe, so downstream logic can run on the master clock with enables instead of derived clocks.
- Sits at the top level, between the master clock and the imem/dmem/processor/regfile clock and enable consumers.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 8, width of the half-period and phase fields.
- INV_MASK, 4'b0000, per-channel reset value of the invert bit (bit i belongs to channel i).

Ports:
- clock  in  1  master clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- sync  in  1  one-cycle pulse that realigns all channels.
- cfg_wr  in  1  configuration write strobe.
- cfg_ch  in  4  channel index for the write.
- cfg_half  in  CNT_W  half-period in master cycles; 0 is treated as 1.
- cfg_phase  in  CNT_W  initial counter offset.
- cfg_inv  in  1  output polarity invert.
- clk_out  out  NUM_CH  divided clocks, registered (glitch-free).
- en_out  out  NUM_CH  one-cycle strobe per channel marking the internal rising edge.
- pending  out  NUM_CH  a shadow configuration is waiting to be applied.
- cfg_err  out  1  one-cycle pulse on a write with cfg_ch >= NUM_CH.

Behaviour:
- Per-channel active registers: half H, phase P, inv, counter cnt, internal clock ci.
- Per-channel shadow registers: H_s, P_s, inv_s, plus the pending flag.
- Output mapping: clk_out[i] = ci ^ inv. en_out[i] is registered and is 1 exactly in the cycle in which ci first reads 1.
- Reset values: H = 2^i (saturated at 2^CNT_W-1), P = 0, inv = INV_MASK[i], cnt = 0, ci = 0, pending = 0, en_out = 0, cfg_err = 0, clk_out = INV_MASK.
- Consequence of reset values: ch0 divides by 2 and ch1 by 4, identical to the legacy chain.
- Counting: each edge, if cnt == H-1 then cnt <= 0 and ci <= ~ci; otherwise cnt <= cnt+1. Output period is 2·H cycles at 50% duty.
- H = 0 (from cfg_half = 0) is stored as 1.
- Phase: P >= H is clamped to H-1 when loaded. With phase P loaded, the first rise of ci occurs H-P edges after the load.
- Config write (cfg_wr and cfg_ch < NUM_CH): capture into the shadow registers and set pending.
  - A second write before application overwrites the shadow; last write wins.
- Config write with cfg_ch >= NUM_CH: ignored; cfg_err = 1 in the next cycle.
- Application: at the edge where cnt == H-1 and ci == 1 (end of a full period), with pending set:
  - H <= H_s, P <= P_s, inv <= inv_s;
  - cnt <= clamped P_s, ci <= 0, pending <= 0.
  - A period is never truncated, and no runt pulse is ever produced.
- sync: on every channel, cnt <= clamped phase, ci <= 0, en_out <= 0.
  - Channels with pending set apply their shadow immediately, then clear pending.
  - cfg_wr in the same cycle as sync is captured and applied by that same sync.
- Precedence: reset > sync > period-end application > normal count.
- Reset mid-period: all state returns to its reset value on the next edge, and pending writes are discarded.
- Latency: cfg_wr to effect is at most 2·H_old cycles; sync to effect is 1 cycle.

Test Plan:
- Release reset at edge 0, defaults -> ch0 clk_out pattern 1,0,1,0 from edge 1; ch1 rises at edge 2, falls at edge 4, period 4. en_out[0] high on edges 1,3,5; en_out[1] high on edges 2,6.
- Write ch2 cfg_half=3, cfg_phase=1 mid-period -> pending[2] = 1 until the end of the current 8-cycle period. Afterwards period 6; first rise 2 edges after application; pending[2] then returns to 0.
- Write ch1 cfg_phase=5 with cfg_half=2 -> phase clamped to 1; first rise 1 edge after application.
- Two writes to ch3 (half 5, then half 7) before its boundary -> only half 7 takes effect; period 14.
- cfg_wr with cfg_ch=9 -> cfg_err pulses one cycle; no channel state or pending flag changes.
- Assert sync together with a ch0 write of cfg_inv=1 -> next cycle all cnt equal their phases and all ci = 0, ch0 clk_out = 1. Reset asserted mid-period -> clk_out = INV_MASK and pending = 0 one edge later.
